clause_loader: RTL and testbench
================================

Name: clause_loader

Overview:
Writer side of the clause-register load bus. Receives clause coefficients word-serially over a valid/ready stream and assembles each clause (all variable coefficients plus bias). It writes each assembled clause to the ClauseRegister bank using the clause-coefficients/clause-index bus, and builds the per-clause reduce-enable mask consumed by the corner-point proposer. Started by the control unit before sampling begins.

Parameters:
- MAXIMUM_BIT_WIDTH_OF_COEFFICIENT, 8, bit width of one signed coefficient/bias.
- MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX, 2, variables = 2**this.
- MAX_BIT_WIDTH_OF_CLAUSES_INDEX, 3, clause slots = 2**this.

Ports:
- in_clk, input, 1, the single clock.
- in_reset, input, 1, synchronous, active-low reset.
- in_start, input, 1, starts a load; honoured only in IDLE.
- in_number_of_clauses, input, MAX_BIT_WIDTH_OF_CLAUSES_INDEX+1, clauses to load; saturated to 2**MAX_BIT_WIDTH_OF_CLAUSES_INDEX.
- in_coefficient, input, MAXIMUM_BIT_WIDTH_OF_COEFFICIENT, one coefficient per beat.
- in_coefficient_valid, input, 1, beat valid.
- out_coefficient_ready, output, 1, beat accepted when valid && ready.
- out_clause_coefficients, output, (2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT, assembled clause.
- out_clause_index, output, MAX_BIT_WIDTH_OF_CLAUSES_INDEX, target slot.
- out_clause_write, output, 1, one-cycle write strobe.
- out_reduce_enable, output, 2**MAX_BIT_WIDTH_OF_CLAUSES_INDEX, bit k = slot k holds a valid clause.
- out_busy, output, 1, high from the accepted start until done.
- out_done, output, 1, one-cycle completion pulse.

Behaviour:
- Reset (in_reset==0 at clock edge): all outputs 0, FSM to IDLE, beat/clause counters 0. This applies mid-operation too: a partial clause is discarded and no strobe is issued.
- IDLE: ready=0, busy=0.
  - On in_start: latch N=min(in_number_of_clauses, 2**C), clear out_reduce_enable, set busy.
  - If N==0, go to DONE; otherwise go to LOAD with clause=0, beat=0.
- LOAD: ready=1.
  - Beat b of a clause lands in slice [b*W +: W].
  - Beats 0..NV-1 are variable coefficients 0..NV-1; beat NV is the bias (top slice).
  - Coefficients pass through bit-exact with no sign handling.
  - Once beat NV is accepted, go to WRITE.
  - valid gaps stall the load without losing or duplicating beats.
- WRITE (exactly one cycle): ready=0, out_clause_write=1, out_clause_index=clause, out_clause_coefficients=assembled clause.
  - On the edge ending WRITE, set out_reduce_enable[clause].
  - If clause==N-1, go to DONE; otherwise clause+1, beat 0, go to LOAD.
- DONE (one cycle): out_done=1, busy=0 on the next edge, return to IDLE. out_reduce_enable holds until the next accepted start or reset.
- Latency: strobe for a clause is asserted the cycle after its last beat is accepted. out_done follows the final WRITE cycle by 1 cycle. Minimum load = N*(NV+2) cycles after start.
- out_clause_coefficients and out_clause_index hold their last written values outside WRITE. This keeps the index-matched ClauseRegister contents stable.
- in_start outside IDLE is ignored. in_coefficient_valid outside LOAD is ignored.
- The clause counter never wraps: N==2**C ends at index 2**C-1.

Decomposition:
- Shared package holds:
  - NUMBER_OF_INTEGER_VARIABLES=2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX
  - COEFFICIENTS_PER_CLAUSE=NV+1
  - CLAUSE_WIDTH
  - NUMBER_OF_CLAUSES=2**MAX_BIT_WIDTH_OF_CLAUSES_INDEX
  - FSM state encoding (IDLE, LOAD, WRITE, DONE)
- One sub-module: clause_assembler. It holds the beat counter and slice-write register, and exposes clear, accept and last_beat.

Test Plan:
- Reset: hold in_reset=0 for 3 cycles with random inputs -> every output 0, ready 0.
- Two-clause load: N=2, beats 1..5 then 6..10 with continuous valid.
  - Strobe at index 0 with 0x0504030201, strobe at index 1 with 0x0A09080706.
  - out_reduce_enable=0x03, single out_done, 14 cycles total.
- Backpressure: same stream with valid every other cycle -> identical strobes/data, no lost or duplicated beat.
- Bounds:
  - N=0 -> out_done the cycle after IDLE start, no strobe, mask 0x00.
  - N=15 -> saturates to 8, indices 0..7, mask 0xFF.
- Negative values: bias beat 0xFE, coefficient 0x80 -> bits appear unchanged in their slices.
- Interference:
  - in_start pulsed during LOAD is ignored.
  - in_reset=0 after 3 beats of clause 1 -> no further strobe, mask 0.
  - A subsequent start with N=1 loads cleanly at index 0.

Source files
------------

// File: rtl/clause_loader_pkg.sv
// Shared widths, sizes and FSM encoding for the clause loader.
// Imported by the stream interface, the assembler and the top.
package clause_loader_pkg;

    localparam int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT = 8;
    localparam int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 2;
    localparam int MAX_BIT_WIDTH_OF_CLAUSES_INDEX = 3;

    localparam int COEF_W = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
    localparam int CIW = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;

    localparam int NUMBER_OF_INTEGER_VARIABLES =
        2 ** MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX;
    localparam int COEFFICIENTS_PER_CLAUSE =
        NUMBER_OF_INTEGER_VARIABLES + 1;
    localparam int CLAUSE_WIDTH =
        COEFFICIENTS_PER_CLAUSE * COEF_W;
    localparam int NUMBER_OF_CLAUSES = 2 ** CIW;
    localparam int BEAT_W = $clog2(COEFFICIENTS_PER_CLAUSE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic logic [CIW:0] saturate_count(
        input logic [CIW:0] n
    );
        if (n > (CIW + 1)'(NUMBER_OF_CLAUSES))
            return (CIW + 1)'(NUMBER_OF_CLAUSES);
        return n;
    endfunction

endpackage

// File: rtl/clause_loader_if.sv
// Word-serial coefficient stream with a valid/ready handshake.
// The loader is the slave; the coefficient source is the master.
interface clause_loader_if;
    import clause_loader_pkg::*;

    logic [COEF_W-1:0] in_coefficient;
    logic              in_coefficient_valid;
    logic              out_coefficient_ready;

    modport master (
        output in_coefficient,
        output in_coefficient_valid,
        input  out_coefficient_ready
    );

    modport slave (
        input  in_coefficient,
        input  in_coefficient_valid,
        output out_coefficient_ready
    );

endinterface

// File: rtl/clause_loader_assembler.sv
// Beat counter plus per-slice capture of the variable coefficients.
// The bias beat is not stored here; the top merges it on the fly.
module clause_assembler
    import clause_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      accept,
    input  logic [COEF_W-1:0]         data,
    output logic                      last_beat,
    output logic [CLAUSE_WIDTH-COEF_W-1:0] variables
);

    logic [BEAT_W-1:0] beat_q;

    assign last_beat =
        (beat_q == BEAT_W'(NUMBER_OF_INTEGER_VARIABLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q    <= '0;
            variables <= '0;
        end else if (clear) begin
            beat_q <= '0;
        end else if (accept) begin
            beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
            for (int b = 0; b < NUMBER_OF_INTEGER_VARIABLES; b++) begin
                if (beat_q == BEAT_W'(b))
                    variables[b*COEF_W +: COEF_W] <= data;
            end
        end
    end

endmodule

// File: rtl/clause_loader.sv
// Assembles clauses from the coefficient stream and writes them
// to the ClauseRegister bank, building the reduce-enable mask.
module clause_loader
    import clause_loader_pkg::*;
(
    input  logic                    in_clk,
    input  logic                    in_reset,
    input  logic                    in_start,
    input  logic [CIW:0]            in_number_of_clauses,
    clause_loader_if.slave          coef_bus,
    output logic [CLAUSE_WIDTH-1:0] out_clause_coefficients,
    output logic [CIW-1:0]          out_clause_index,
    output logic                    out_clause_write,
    output logic [NUMBER_OF_CLAUSES-1:0] out_reduce_enable,
    output logic                    out_busy,
    output logic                    out_done
);

    state_t state_q, state_d;

    logic [CIW:0]   n_q;
    logic [CIW-1:0] clause_q;
    logic           ready;
    logic           accept;
    logic           clear;
    logic           last_beat;
    logic           last_clause;
    logic           start_ok;
    logic [CLAUSE_WIDTH-COEF_W-1:0] variables;

    assign coef_bus.out_coefficient_ready = ready;
    assign accept = coef_bus.in_coefficient_valid && (state_q == S_LOAD);
    assign start_ok = in_start && (state_q == S_IDLE);
    assign last_clause =
        (({1'b0, clause_q} + (CIW + 1)'(1)) == n_q);

    clause_assembler u_assembler (
        .clk       (in_clk),
        .rst_n     (in_reset),
        .clear     (clear),
        .accept    (accept),
        .data      (coef_bus.in_coefficient),
        .last_beat (last_beat),
        .variables (variables)
    );

    always_ff @(posedge in_clk) begin
        if (!in_reset) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        ready            = 1'b0;
        out_clause_write = 1'b0;
        out_done         = 1'b0;
        clear            = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    clear   = 1'b1;
                    state_d = (saturate_count(in_number_of_clauses) == '0)
                            ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                ready = 1'b1;
                if (accept && last_beat) state_d = S_WRITE;
            end
            S_WRITE: begin
                out_clause_write = 1'b1;
                state_d = last_clause ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                out_done = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    // Output bus is captured on the bias beat so it holds between writes.
    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            n_q                     <= '0;
            clause_q                <= '0;
            out_reduce_enable       <= '0;
            out_busy                <= 1'b0;
            out_clause_coefficients <= '0;
            out_clause_index        <= '0;
        end else begin
            if (start_ok) begin
                n_q               <= saturate_count(in_number_of_clauses);
                clause_q          <= '0;
                out_reduce_enable <= '0;
                out_busy          <= 1'b1;
            end
            if (accept && last_beat) begin
                out_clause_coefficients <=
                    {coef_bus.in_coefficient, variables};
                out_clause_index <= clause_q;
            end
            if (state_q == S_WRITE) begin
                out_reduce_enable[clause_q] <= 1'b1;
                if (!last_clause) clause_q <= clause_q + CIW'(1);
            end
            if (state_q == S_DONE) out_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clause_loader.sv
// Randomized self-checking bench for clause_loader against a
// queue-based model of the expected clause writes and mask.
module tb_clause_loader;
    import clause_loader_pkg::*;

    typedef struct {
        int         idx;
        logic [39:0] data;
    } wr_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [3:0]  num = 0;
    logic [39:0] coefs;
    logic [2:0]  idx;
    logic        wr;
    logic [7:0]  mask;
    logic        busy;
    logic        done;

    clause_loader_if bus ();

    clause_loader dut (
        .in_clk                  (clk),
        .in_reset                (rst_n),
        .in_start                (start),
        .in_number_of_clauses    (num),
        .coef_bus                (bus.slave),
        .out_clause_coefficients (coefs),
        .out_clause_index        (idx),
        .out_clause_write        (wr),
        .out_reduce_enable       (mask),
        .out_busy                (busy),
        .out_done                (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_on = 0;
    logic [7:0]  exp_mask = 0;
    logic [7:0]  beats[$];
    wr_t         exp_q[$];
    logic [39:0] wr_log[$];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Scoreboard: every strobe must match the next modelled write.
    always @(negedge clk) begin
        if (mon_on) begin
            check("mask", 64'(mask), 64'(exp_mask));
            if (wr) begin
                wr_t w;
                check("ready_in_write", 64'(bus.out_coefficient_ready), 0);
                wr_log.push_back(coefs);
                if (exp_q.size() == 0) begin
                    check("spurious_write", 64'(wr), 0);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_index", 64'(idx), 64'(w.idx));
                    check("wr_data", 64'(coefs), 64'(w.data));
                    exp_mask = exp_mask | (8'd1 << w.idx);
                end
            end
        end
    end

    task automatic run_load(input int n_req, input int mode,
                            input int pulse_t, input int abort_at,
                            output int cycles);
        int  n_eff, total, i;
        bit  done_seen, aborted;
        logic acc;
        n_eff = (n_req > 8) ? 8 : n_req;
        total = n_eff * 5;
        while (beats.size() < total) beats.push_back(8'($urandom));
        for (int k = 0; k < n_eff; k++) begin
            wr_t w;
            if (abort_at < 0 || (k + 1) * 5 <= abort_at) begin
                w.idx = k;
                for (int b = 0; b < 5; b++)
                    w.data[b*8 +: 8] = beats[k*5 + b];
                exp_q.push_back(w);
            end
        end
        wr_log.delete();
        i = 0;
        cycles = 0;
        done_seen = 0;
        aborted = 0;
        @(negedge clk);
        for (int t = 0; t < 400 && !done_seen && !aborted; t++) begin
            if (t == 0) begin
                start = 1;
                num = 4'(n_req);
                check("busy_before_start", 64'(busy), 0);
            end else begin
                start = (t == pulse_t);
                if (t == pulse_t) num = 4'($urandom);
            end
            if (abort_at >= 0 && i == abort_at) begin
                rst_n = 0;
                bus.in_coefficient_valid = 0;
                @(posedge clk);
                exp_q.delete();
                exp_mask = 0;
                @(negedge clk);
                rst_n = 1;
                start = 0;
                aborted = 1;
            end else begin
                case (mode)
                    0: bus.in_coefficient_valid = 1;
                    1: bus.in_coefficient_valid = t[0];
                    default: bus.in_coefficient_valid = 1'($urandom);
                endcase
                bus.in_coefficient = (i < total) ? beats[i] : 8'($urandom);
                acc = bus.in_coefficient_valid && bus.out_coefficient_ready;
                if (done) begin
                    done_seen = 1;
                    cycles = t + 1;
                    check("busy_in_done", 64'(busy), 1);
                end
                @(posedge clk);
                if (t == 0) exp_mask = 0;
                if (acc) i++;
                @(negedge clk);
            end
        end
        start = 0;
        bus.in_coefficient_valid = 0;
        beats.delete();
        if (aborted) return;
        check("done_seen", 64'(done_seen), 1);
        check("beats_used", 64'(i), 64'(total));
        check("writes_left", 64'(exp_q.size()), 0);
        check("final_mask", 64'(mask), 64'((1 << n_eff) - 1));
        repeat (3) begin
            bus.in_coefficient_valid = 1'($urandom);
            bus.in_coefficient = 8'($urandom);
            check("idle_done", 64'(done), 0);
            check("idle_busy", 64'(busy), 0);
            check("idle_ready", 64'(bus.out_coefficient_ready), 0);
            @(negedge clk);
        end
        bus.in_coefficient_valid = 0;
    endtask

    initial begin
        int cyc;
        bus.in_coefficient = 0;
        bus.in_coefficient_valid = 0;

        repeat (3) begin
            @(negedge clk);
            start = 1'($urandom);
            num = 4'($urandom);
            bus.in_coefficient_valid = 1'($urandom);
            bus.in_coefficient = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("rst_coefs", 64'(coefs), 0);
            check("rst_idx", 64'(idx), 0);
            check("rst_wr", 64'(wr), 0);
            check("rst_mask", 64'(mask), 0);
            check("rst_busy", 64'(busy), 0);
            check("rst_done", 64'(done), 0);
            check("rst_ready", 64'(bus.out_coefficient_ready), 0);
        end
        start = 0;
        bus.in_coefficient_valid = 0;
        rst_n = 1;
        exp_mask = 0;
        mon_on = 1;

        for (int m = 0; m < 2; m++) begin
            for (int b = 1; b <= 10; b++) beats.push_back(8'(b));
            run_load(2, m, -1, -1, cyc);
            if (m == 0) check("two_cycles", 64'(cyc), 14);
            else check("bp_slower", 64'(cyc > 14), 1);
            check("log_size", 64'(wr_log.size()), 2);
            if (wr_log.size() == 2) begin
                check("clause0_lit", 64'(wr_log[0]), 64'h05_0403_0201);
                check("clause1_lit", 64'(wr_log[1]), 64'h0A_0908_0706);
            end
            check("hold_coefs", 64'(coefs), 64'h0A_0908_0706);
            check("hold_idx", 64'(idx), 1);
            check("mask_lit", 64'(mask), 64'h03);
        end

        run_load(0, 0, -1, -1, cyc);
        check("n0_cycles", 64'(cyc), 2);
        check("n0_writes", 64'(wr_log.size()), 0);
        check("n0_mask", 64'(mask), 0);

        run_load(15, 2, -1, -1, cyc);
        check("n15_writes", 64'(wr_log.size()), 8);
        check("n15_mask", 64'(mask), 64'hFF);
        check("n15_last_idx", 64'(idx), 7);

        beats.push_back(8'h80);
        repeat (3) beats.push_back(8'($urandom));
        beats.push_back(8'hFE);
        run_load(1, 0, -1, -1, cyc);
        check("neg_bias", 64'(coefs[39:32]), 64'hFE);
        check("neg_coef0", 64'(coefs[7:0]), 64'h80);
        check("n1_cycles", 64'(cyc), 8);

        run_load(3, 0, 3, -1, cyc);
        check("pulse_cycles", 64'(cyc), 20);

        run_load(2, 0, -1, 8, cyc);
        repeat (12) begin
            check("abort_mask", 64'(mask), 0);
            check("abort_busy", 64'(busy), 0);
            @(negedge clk);
        end
        check("abort_writes", 64'(wr_log.size()), 1);

        run_load(1, 1, -1, -1, cyc);
        check("reload_writes", 64'(wr_log.size()), 1);
        check("reload_idx", 64'(idx), 0);

        for (int r = 0; r < 6; r++)
            run_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                     int'($urandom_range(2, 30)), -1, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
